write_only_reg_bank: RTL and testbench
======================================

WRITE_ONLY_REG_BANK -- requirements
Module: write_only_reg_bank

Interface
REQ-001 The block SHALL have parameter NUM_REGS, default 4, number of write-only channels (1..15).
REQ-002 The block SHALL have parameter WID_DATA, default 32, channel width in bits.
REQ-003 The block SHALL have parameter RST_VALUE [WID_DATA-1:0], default 0, reset value of every channel.
REQ-004 The block SHALL have localparam WID_ADDR = clog2(NUM_REGS+1).
REQ-005 The block SHALL have port Sys_Clock, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port Sys_Reset, input, 1 bit, asynchronous, active-low reset.
REQ-007 The block SHALL have port Sys_WE, input, 1 bit, write request; held until accepted.
REQ-008 The block SHALL have port Sys_Addr, input, WID_ADDR bits, channel index; value NUM_REGS is the commit address.
REQ-009 The block SHALL have port Sys_Data, input, WID_DATA bits, write data, or the commit mask when Sys_Addr = NUM_REGS.
REQ-010 The block SHALL have port Sys_Ready, output, 1 bit, write accept; a write is accepted on an edge where Sys_WE & Sys_Ready.
REQ-011 The block SHALL have port Reg_DataOut, output, NUM_REGS*WID_DATA bits, channel i in slice [i*WID_DATA +: WID_DATA].
REQ-012 The block SHALL have port Reg_Update, output, NUM_REGS bits, a one-cycle pulse per channel whose output was loaded.
REQ-013 The block SHALL have port Reg_Pending, output, NUM_REGS bits, shadow written but not yet committed.

Function
REQ-014 The block SHALL use an FSM with states IDLE and COMMIT; Sys_Ready = 1 in IDLE and 0 in COMMIT.
REQ-015 An accepted write with Sys_Addr = i < NUM_REGS SHALL load shadow i and set Reg_Pending[i] at that edge; Reg_DataOut SHALL be unchanged.
REQ-016 Rewriting a pending channel SHALL overwrite its shadow, and Reg_Pending[i] SHALL stay 1.
REQ-017 An accepted write to the commit address SHALL latch mask = Sys_Data[NUM_REGS-1:0] & Reg_Pending and SHALL move the FSM IDLE->COMMIT.
REQ-018 On the edge leaving COMMIT, each channel set in the mask SHALL copy shadow -> Reg_DataOut, SHALL clear Reg_Pending, and SHALL assert Reg_Update for exactly one cycle; the FSM SHALL return to IDLE. Commit latency is 2 edges from acceptance to the new value.
REQ-019 All channels in one commit SHALL update on the same edge (atomic).
REQ-020 A commit whose mask is all-zero SHALL still take the COMMIT cycle and SHALL produce no Reg_Update.
REQ-021 An address greater than NUM_REGS SHALL be accepted and ignored.
REQ-022 Sys_WE while in COMMIT SHALL NOT be accepted, and the requester SHALL hold it.
REQ-023 Reg_Update SHALL be 0 in every cycle not following a COMMIT exit.

Reset
REQ-024 Sys_Reset low SHALL immediately force the following, independent of clock: Reg_DataOut = RST_VALUE in every slice, shadows = RST_VALUE, Reg_Pending = 0, Reg_Update = 0, FSM = IDLE, Sys_Ready = 1.
REQ-025 Reset asserted during COMMIT SHALL abort the commit, and no channel SHALL update.
REQ-026 Deassertion SHALL be synchronised externally; the first write SHALL be accepted on the first edge after release.

Configuration
REQ-027 The feature SHALL be controlled by macro WOREG_SHADOW_EN.
REQ-028 With WOREG_SHADOW_EN defined, shadow/commit behaviour SHALL be as REQ-014..REQ-022.
REQ-029 Without WOREG_SHADOW_EN, no shadows and no FSM SHALL exist; an accepted write to i < NUM_REGS SHALL load Reg_DataOut slice i at that edge and pulse Reg_Update[i] in the following cycle; the commit address SHALL be ignored; Reg_Pending SHALL be tied 0 and Sys_Ready tied 1.

Structure
REQ-030 The shared package/header wo_reg_pkg SHALL hold the FSM state encoding (IDLE = 0, COMMIT = 1) and the commit-address offset constant.
REQ-031 Per-channel storage SHALL be one sub-module, wo_reg_channel (shadow, output register, pending bit), instantiated NUM_REGS times via generate.

Verification
REQ-032 Reset mid-run: assert Sys_Reset low asynchronously -> all slices = RST_VALUE and Pending = 0 with no clock edge.
REQ-033 Shadow write then commit (shadow on): write ch1 = 0xA5A5_0001, commit mask 0xF -> Reg_DataOut[1] unchanged until 2 edges after the commit; Update = 4'b0010 for one cycle; Pending = 0.
REQ-034 Atomic commit: write ch0 = 0x11 and ch3 = 0x33, commit mask 0x9 -> both slices change on the same edge; Update = 4'b1001.
REQ-035 Masked or empty commit: pending ch2, commit mask 0x1 -> no update and Pending[2] stays 1; commit mask 0 -> Sys_Ready low for 1 cycle, Update = 0.
REQ-036 Stall: hold Sys_WE to ch0 during COMMIT -> write accepted on the first IDLE edge; data not lost.
REQ-037 Direct mode (macro off): write ch2 = 0xDEAD_BEEF -> slice 2 = value after 1 edge, Update[2] pulses, and a write to address 4 has no effect.

Source files
------------

// File: rtl/wo_reg_pkg.sv
// Shared definitions for the write-only register bank: FSM state encoding
// and where the commit address sits relative to the channel count.
package wo_reg_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_COMMIT = 1'b1
  } state_e;

  // Commit address = NUM_REGS + offset (first index past the channels).
  localparam int COMMIT_ADDR_OFS = 0;

  function automatic int commit_addr(input int num_regs);
    return num_regs + COMMIT_ADDR_OFS;
  endfunction

endpackage

// File: rtl/wo_reg_channel.sv
// One write-only channel. With WOREG_SHADOW_EN a write lands in a shadow
// and only reaches the output on commit_i; otherwise writes go straight
// to the output register.
module wo_reg_channel #(
  parameter int                  WID_DATA  = 32,
  parameter logic [WID_DATA-1:0] RST_VALUE = '0
) (
  input  logic                gclk,
  input  logic                grst_n,
  input  logic                wr_i,
  input  logic [WID_DATA-1:0] data_i,
`ifdef WOREG_SHADOW_EN
  input  logic                commit_i,
  output logic                pend_o,
`endif
  output logic [WID_DATA-1:0] dout_o,
  output logic                upd_o
);

  logic [WID_DATA-1:0] dout_q;
  logic                upd_q;

`ifdef WOREG_SHADOW_EN
  logic [WID_DATA-1:0] shadow_q;
  logic                pend_q;

  // Commit copies shadow to output; writes never coincide with a commit
  // because the bank is not ready while committing.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      shadow_q <= RST_VALUE;
      dout_q   <= RST_VALUE;
      pend_q   <= 1'b0;
      upd_q    <= 1'b0;
    end else begin
      upd_q <= commit_i;
      if (commit_i) begin
        dout_q <= shadow_q;
        pend_q <= 1'b0;
      end else if (wr_i) begin
        shadow_q <= data_i;
        pend_q   <= 1'b1;
      end
    end
  end

  assign pend_o = pend_q;
`else
  // Direct write: output loads at the accepting edge, update pulses after.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      dout_q <= RST_VALUE;
      upd_q  <= 1'b0;
    end else begin
      upd_q <= wr_i;
      if (wr_i) dout_q <= data_i;
    end
  end
`endif

  assign dout_o = dout_q;
  assign upd_o  = upd_q;

endmodule

// File: rtl/write_only_reg_bank.sv
// Bank of NUM_REGS write-only channels. Define WOREG_SHADOW_EN for
// shadow + atomic masked commit (address NUM_REGS); without it, writes
// update the outputs directly and the commit address is ignored.
module write_only_reg_bank
  import wo_reg_pkg::*;
#(
  parameter int                  NUM_REGS  = 4,
  parameter int                  WID_DATA  = 32,
  parameter logic [WID_DATA-1:0] RST_VALUE = '0,
  localparam int                 WID_ADDR  = $clog2(NUM_REGS + 1)
) (
  input  logic                         Sys_Clock,
  input  logic                         Sys_Reset,
  input  logic                         Sys_WE,
  input  logic [WID_ADDR-1:0]          Sys_Addr,
  input  logic [WID_DATA-1:0]          Sys_Data,
  output logic                         Sys_Ready,
  output logic [NUM_REGS*WID_DATA-1:0] Reg_DataOut,
  output logic [NUM_REGS-1:0]          Reg_Update,
  output logic [NUM_REGS-1:0]          Reg_Pending
);

  logic [NUM_REGS-1:0][WID_DATA-1:0] dout_w;
  logic [NUM_REGS-1:0]               wr_w;
  logic [NUM_REGS-1:0]               upd_w;
  logic                              accept_w;

  assign accept_w = Sys_WE & Sys_Ready;

  // Address decode to per-channel write strobes; out-of-range hits nothing.
  always_comb begin
    wr_w = '0;
    for (int i = 0; i < NUM_REGS; i++)
      wr_w[i] = accept_w && (Sys_Addr == WID_ADDR'(i));
  end

`ifdef WOREG_SHADOW_EN
  state_e              state_q, state_d;
  logic [NUM_REGS-1:0] mask_q;
  logic [NUM_REGS-1:0] commit_w;
  logic [NUM_REGS-1:0] pend_w;
  logic                commit_hit_w;

  assign commit_hit_w = accept_w && (Sys_Addr == WID_ADDR'(commit_addr(NUM_REGS)));

  // State register.
  always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
    if (!Sys_Reset) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Next state: a commit request costs exactly one COMMIT cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (commit_hit_w) state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs: stall writers while committing; fire the latched mask.
  always_comb begin
    Sys_Ready = (state_q == ST_IDLE);
    commit_w  = (state_q == ST_COMMIT) ? mask_q : '0;
  end

  // Only channels pending at request time take part in the commit.
  always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
    if (!Sys_Reset)        mask_q <= '0;
    else if (commit_hit_w) mask_q <= Sys_Data[NUM_REGS-1:0] & pend_w;
  end

  assign Reg_Pending = pend_w;
`else
  assign Sys_Ready   = 1'b1;
  assign Reg_Pending = '0;
`endif

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_ch
    wo_reg_channel #(
      .WID_DATA  (WID_DATA),
      .RST_VALUE (RST_VALUE)
    ) u_ch (
      .gclk     (Sys_Clock),
      .grst_n   (Sys_Reset),
      .wr_i     (wr_w[g]),
      .data_i   (Sys_Data),
`ifdef WOREG_SHADOW_EN
      .commit_i (commit_w[g]),
      .pend_o   (pend_w[g]),
`endif
      .dout_o   (dout_w[g]),
      .upd_o    (upd_w[g])
    );
  end

  assign Reg_DataOut = dout_w;
  assign Reg_Update  = upd_w;

endmodule

// File: tb/tb_write_only_reg_bank.sv
// Bench for write_only_reg_bank: directed literal checks plus randomized
// traffic compared every cycle against an array-based model.
module tb_write_only_reg_bank;

  localparam int          N   = 4;
  localparam int          W   = 32;
  localparam int          ADW = $clog2(N + 1);
  localparam logic [31:0] R   = 32'h5A5A_0F0F;

  logic           Sys_Clock = 1'b0;
  logic           Sys_Reset;
  logic           Sys_WE;
  logic [ADW-1:0] Sys_Addr;
  logic [W-1:0]   Sys_Data;
  logic           Sys_Ready;
  logic [N*W-1:0] Reg_DataOut;
  logic [N-1:0]   Reg_Update;
  logic [N-1:0]   Reg_Pending;

  write_only_reg_bank #(.NUM_REGS(N), .WID_DATA(W), .RST_VALUE(R)) dut (
    .Sys_Clock   (Sys_Clock),
    .Sys_Reset   (Sys_Reset),
    .Sys_WE      (Sys_WE),
    .Sys_Addr    (Sys_Addr),
    .Sys_Data    (Sys_Data),
    .Sys_Ready   (Sys_Ready),
    .Reg_DataOut (Reg_DataOut),
    .Reg_Update  (Reg_Update),
    .Reg_Pending (Reg_Pending)
  );

  always #5 Sys_Clock = ~Sys_Clock;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] sl(input int i);
    return Reg_DataOut[i*W +: W];
  endfunction

  // Behavioural model: outputs, shadows, pending set, and a commit in flight.
  logic [31:0] out_m[N];
  logic [31:0] sh_m[N];
  logic [N-1:0] pend_m, upd_m, mask_m;
  bit busy_m;

  always @(posedge Sys_Clock or negedge Sys_Reset) begin
    if (!Sys_Reset) begin
      for (int i = 0; i < N; i++) begin out_m[i] = R; sh_m[i] = R; end
      pend_m = '0; upd_m = '0; mask_m = '0; busy_m = 0;
    end else begin
      upd_m = '0;
`ifdef WOREG_SHADOW_EN
      if (busy_m) begin
        for (int i = 0; i < N; i++)
          if (mask_m[i]) begin out_m[i] = sh_m[i]; pend_m[i] = 1'b0; upd_m[i] = 1'b1; end
        busy_m = 0;
      end else if (Sys_WE) begin
        if (int'(Sys_Addr) < N) begin
          sh_m[Sys_Addr] = Sys_Data; pend_m[Sys_Addr] = 1'b1;
        end else if (int'(Sys_Addr) == N) begin
          mask_m = Sys_Data[N-1:0] & pend_m; busy_m = 1;
        end
      end
`else
      if (Sys_WE && int'(Sys_Addr) < N) begin
        out_m[Sys_Addr] = Sys_Data; upd_m[Sys_Addr] = 1'b1;
      end
`endif
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge Sys_Clock) begin
    if (chk_en) begin
      logic [N*W-1:0] e;
      for (int i = 0; i < N; i++) e[i*W +: W] = out_m[i];
      chk("dout", Reg_DataOut, e);
      chk("update", Reg_Update, upd_m);
      chk("pending", Reg_Pending, pend_m);
      chk("ready", Sys_Ready, !busy_m);
    end
  end

  task automatic step();
    @(negedge Sys_Clock); #1;
  endtask

  // Issue one write, holding it until accepted; returns just after the
  // negedge following the accepting edge.
  task automatic wr(input int a, input logic [31:0] d);
    int t = 0;
    Sys_WE = 1'b1; Sys_Addr = ADW'(a); Sys_Data = d;
    while (!Sys_Ready && t < 20) begin step(); t++; end
    if (t >= 20) begin
      n_vec++; n_err++;
      $display("FAIL wr_timeout: got ready=0 want ready=1 within 20 cycles");
    end
    step();
    Sys_WE = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    Sys_Reset = 1'b1; Sys_WE = 1'b0; Sys_Addr = '0; Sys_Data = '0;
    #1 Sys_Reset = 1'b0;
    #2;
    chk("rst_dout", Reg_DataOut, {N{R}});
    chk("rst_pend", Reg_Pending, 4'b0000);
    chk("rst_upd", Reg_Update, 4'b0000);
    chk("rst_ready", Sys_Ready, 1'b1);
    step(); step();
    Sys_Reset = 1'b1;
    chk_en = 1;

`ifdef WOREG_SHADOW_EN
    wr(1, 32'hA5A5_0001);
    chk("sh_pend1", Reg_Pending, 4'b0010);
    chk("sh_hold1", sl(1), R);
    wr(4, 32'hF);
    chk("cm_ready", Sys_Ready, 1'b0);
    chk("cm_hold1", sl(1), R);
    chk("cm_noupd", Reg_Update, 4'b0000);
    step();
    chk("cm_data1", sl(1), 32'hA5A5_0001);
    chk("cm_upd", Reg_Update, 4'b0010);
    chk("cm_pend", Reg_Pending, 4'b0000);
    step();
    chk("cm_upd_once", Reg_Update, 4'b0000);

    wr(0, 32'h11); wr(3, 32'h33); wr(4, 32'h9);
    chk("at_old0", sl(0), R);
    chk("at_old3", sl(3), R);
    step();
    chk("at_new0", sl(0), 32'h11);
    chk("at_new3", sl(3), 32'h33);
    chk("at_upd", Reg_Update, 4'b1001);

    wr(2, 32'h77); wr(4, 32'h1);
    step();
    chk("mk_upd", Reg_Update, 4'b0000);
    chk("mk_pend", Reg_Pending, 4'b0100);
    wr(4, 32'h0);
    chk("em_ready", Sys_Ready, 1'b0);
    step();
    chk("em_ready2", Sys_Ready, 1'b1);
    chk("em_upd", Reg_Update, 4'b0000);
    chk("em_pend", Reg_Pending, 4'b0100);

    wr(4, 32'h4);
    wr(0, 32'hCAFE_0000);
    chk("st_pend", Reg_Pending, 4'b0001);
    chk("st_data2", sl(2), 32'h77);
    wr(4, 32'h1);
    step();
    chk("st_data0", sl(0), 32'hCAFE_0000);
    chk("st_upd", Reg_Update, 4'b0001);

    wr(1, 32'h123); wr(4, 32'h2);
`else
    wr(2, 32'hDEAD_BEEF);
    chk("dm_data2", sl(2), 32'hDEAD_BEEF);
    chk("dm_upd", Reg_Update, 4'b0100);
    chk("dm_pend", Reg_Pending, 4'b0000);
    step();
    chk("dm_upd_once", Reg_Update, 4'b0000);
    wr(4, 32'h1234_5678);
    chk("dm_commit_ign", Reg_DataOut, {R, 32'hDEAD_BEEF, R, R});
    chk("dm_commit_upd", Reg_Update, 4'b0000);
    wr(6, 32'h0BAD_0BAD);
    chk("dm_oor_ign", Reg_DataOut, {R, 32'hDEAD_BEEF, R, R});
    wr(1, 32'h123);
`endif
    // Asynchronous reset mid-run (and mid-commit when shadows exist).
    #1 Sys_Reset = 1'b0;
    #1;
    chk("ar_dout", Reg_DataOut, {N{R}});
    chk("ar_pend", Reg_Pending, 4'b0000);
    chk("ar_upd", Reg_Update, 4'b0000);
    chk("ar_ready", Sys_Ready, 1'b1);
    step();
    Sys_Reset = 1'b1;
    step();
    chk("ar_abort1", sl(1), R);
    chk("ar_abort_upd", Reg_Update, 4'b0000);

    // Randomized traffic; a stalled request is held until accepted.
    for (int n = 0; n < 3000; n++) begin
      step();
      if (!(Sys_WE && !Sys_Ready)) begin
        Sys_WE   = ($urandom % 3) != 0;
        Sys_Addr = ADW'($urandom_range(0, 7));
        Sys_Data = (int'(Sys_Addr) == N) ? 32'($urandom_range(0, 15)) : $urandom;
      end
      if ($urandom % 250 == 0) begin
        #1 Sys_Reset = 1'b0;
        #1 Sys_Reset = 1'b1;
      end
    end
    Sys_WE = 1'b0;
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
